product_accumulator: RTL and testbench

Downstream consumer of the 32x32 multiplier's 64-bit product. It sums a fixed group of COUNT unsigned products into a wide accumulator, then presents the group sum on a valid/ready output and holds it until the consumer accepts it. Products arrive with a valid strobe generated by the integration logic alongside the multiplier's out bus. A synchronous clear discards any partial group.

---
 rtl/product_accumulator.sv | 121 ++++++++++++
 tb/tb_product_accumulator.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// ============================================================================
// Module   : product_accumulator
// Summary  : Sums groups of COUNT unsigned 64-bit products and offers each
//            group sum on a valid/ready output with a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module product_accumulator #(
  parameter int COUNT = 8,
  parameter int ACC_W = 72
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [63:0]      product_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             sum_valid_o,
  input  logic             sum_ready_i,
  output logic             overflow_o,
  output logic [7:0]       count_o
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [7:0] c_LAST = 8'(COUNT - 1);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         count_q, count_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               overflow_q, overflow_d;
  logic               sum_valid_q, sum_valid_d;

  // One extra bit captures the carry out of the accumulator width.
  logic [ACC_W:0]     w_add;
  assign w_add = {1'b0, acc_q} + (ACC_W + 1)'(product_i);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_ACCUM;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      count_q     <= '0;
      sum_q       <= '0;
      overflow_q  <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      count_q     <= count_d;
      sum_q       <= sum_d;
      overflow_q  <= overflow_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    count_d     = count_q;
    sum_d       = sum_q;
    overflow_d  = overflow_q;
    sum_valid_d = sum_valid_q;

    if (clear_i) begin
      state_d     = ST_ACCUM;
      acc_d       = '0;
      ovf_d       = 1'b0;
      count_d     = '0;
      sum_d       = '0;
      overflow_d  = 1'b0;
      sum_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (in_valid_i) begin
            if (count_q == c_LAST) begin
              sum_d       = w_add[ACC_W-1:0];
              overflow_d  = ovf_q | w_add[ACC_W];
              sum_valid_d = 1'b1;
              acc_d       = '0;
              ovf_d       = 1'b0;
              count_d     = '0;
              state_d     = ST_HOLD;
            end else begin
              acc_d   = w_add[ACC_W-1:0];
              ovf_d   = ovf_q | w_add[ACC_W];
              count_d = count_q + 8'd1;
            end
          end
        end
        ST_HOLD: begin
          // Products offered while holding are dropped; only the consumer handshake moves on.
          if (sum_ready_i) begin
            sum_valid_d = 1'b0;
            state_d     = ST_ACCUM;
          end
        end
        default: state_d = ST_ACCUM;
      endcase
    end
  end

  assign in_ready_o  = (state_q == ST_ACCUM);
  assign sum_o       = sum_q;
  assign sum_valid_o = sum_valid_q;
  assign overflow_o  = overflow_q;
  assign count_o     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_product_accumulator.sv
// ============================================================================
// Module   : tb_product_accumulator
// Summary  : Directed scoreboard bench for product_accumulator (COUNT=4/ACC_W=72
//            and COUNT=2/ACC_W=64 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_product_accumulator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: COUNT=4, ACC_W=72
  logic        a_rst, a_clear, a_valid, a_ready, a_sum_valid, a_sum_ready, a_ovf;
  logic [63:0] a_prod;
  logic [71:0] a_sum;
  logic [7:0]  a_count;

  // Instance B: COUNT=2, ACC_W=64
  logic        b_rst, b_clear, b_valid, b_ready, b_sum_valid, b_sum_ready, b_ovf;
  logic [63:0] b_prod;
  logic [63:0] b_sum;
  logic [7:0]  b_count;

  product_accumulator #(.COUNT(4), .ACC_W(72)) u_dut_a (
    .clock_i    (clk),
    .reset_i    (a_rst),
    .clear_i    (a_clear),
    .in_valid_i (a_valid),
    .in_ready_o (a_ready),
    .product_i  (a_prod),
    .sum_o      (a_sum),
    .sum_valid_o(a_sum_valid),
    .sum_ready_i(a_sum_ready),
    .overflow_o (a_ovf),
    .count_o    (a_count)
  );

  product_accumulator #(.COUNT(2), .ACC_W(64)) u_dut_b (
    .clock_i    (clk),
    .reset_i    (b_rst),
    .clear_i    (b_clear),
    .in_valid_i (b_valid),
    .in_ready_o (b_ready),
    .product_i  (b_prod),
    .sum_o      (b_sum),
    .sum_valid_o(b_sum_valid),
    .sum_ready_i(b_sum_ready),
    .overflow_o (b_ovf),
    .count_o    (b_count)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Expected transfers: {overflow, sum}
  logic [72:0] exp_a_q[$];
  logic [64:0] exp_b_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitors: every completed handshake is checked against the scoreboard.
  always @(negedge clk) begin
    if (a_sum_valid === 1'b1 && a_sum_ready === 1'b1) begin
      if (exp_a_q.size() == 0) begin
        chk("A unexpected sum", {55'd0, a_ovf, a_sum}, 128'hDEAD);
      end else begin
        logic [72:0] e;
        e = exp_a_q.pop_front();
        chk("A sum", {56'd0, a_sum}, {56'd0, e[71:0]});
        chk("A overflow", {127'd0, a_ovf}, {127'd0, e[72]});
      end
    end
  end

  always @(negedge clk) begin
    if (b_sum_valid === 1'b1 && b_sum_ready === 1'b1) begin
      if (exp_b_q.size() == 0) begin
        chk("B unexpected sum", {63'd0, b_ovf, b_sum}, 128'hDEAD);
      end else begin
        logic [64:0] e;
        e = exp_b_q.pop_front();
        chk("B sum", {64'd0, b_sum}, {64'd0, e[63:0]});
        chk("B overflow", {127'd0, b_ovf}, {127'd0, e[64]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_acc(input logic [63:0] p);
    a_valid = 1'b1;
    a_prod  = p;
    tick();
  endtask

  task automatic b_acc(input logic [63:0] p);
    b_valid = 1'b1;
    b_prod  = p;
    tick();
  endtask

  task automatic a_idle(input int n);
    a_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [7:0] cnt_exp [7];
    logic       vpat    [7];
    logic [63:0] gp     [7];
    int          k;

    a_rst = 1'b1; a_clear = 1'b0; a_valid = 1'b0; a_prod = '0; a_sum_ready = 1'b0;
    b_rst = 1'b1; b_clear = 1'b0; b_valid = 1'b0; b_prod = '0; b_sum_ready = 1'b0;
    #3;
    chk("reset sum", {56'd0, a_sum}, 128'd0);
    chk("reset sum_valid", {127'd0, a_sum_valid}, 128'd0);
    chk("reset in_ready", {127'd0, a_ready}, 128'd1);
    chk("reset count", {120'd0, a_count}, 128'd0);
    chk("reset overflow", {127'd0, a_ovf}, 128'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();

    // Basic group, consumer always ready
    a_sum_ready = 1'b1;
    a_acc(64'd300);
    chk("count after 1st", {120'd0, a_count}, 128'd1);
    a_acc(64'd300);
    a_acc(64'd300);
    exp_a_q.push_back({1'b0, 72'd1300});
    a_acc(64'd400);
    a_valid = 1'b0;
    chk("sum_valid after final", {127'd0, a_sum_valid}, 128'd1);
    chk("in_ready in HOLD", {127'd0, a_ready}, 128'd0);
    chk("count after final", {120'd0, a_count}, 128'd0);
    tick();
    chk("in_ready after transfer", {127'd0, a_ready}, 128'd1);
    chk("sum_valid after transfer", {127'd0, a_sum_valid}, 128'd0);

    // Backpressure: held sum stays put while upstream keeps offering 999
    a_sum_ready = 1'b0;
    a_acc(64'd300);
    a_acc(64'd300);
    a_acc(64'd300);
    exp_a_q.push_back({1'b0, 72'd1300});
    a_acc(64'd400);
    a_prod = 64'd999;
    for (int i = 0; i < 5; i++) begin
      chk("held sum", {56'd0, a_sum}, 128'd1300);
      chk("held in_ready", {127'd0, a_ready}, 128'd0);
      tick();
    end
    a_sum_ready = 1'b1;
    tick();
    a_acc(64'd5);
    a_acc(64'd5);
    a_acc(64'd5);
    exp_a_q.push_back({1'b0, 72'd20});
    a_acc(64'd5);
    a_idle(2);

    // Clear mid-group with a simultaneous product
    a_acc(64'd300);
    a_acc(64'd300);
    a_clear = 1'b1;
    a_acc(64'd300);
    a_clear = 1'b0;
    chk("count after clear", {120'd0, a_count}, 128'd0);
    a_acc(64'd100);
    a_acc(64'd200);
    a_acc(64'd300);
    exp_a_q.push_back({1'b0, 72'd1000});
    a_acc(64'd400);
    a_idle(2);

    // Gapped in_valid
    vpat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    cnt_exp = '{8'd1, 8'd1, 8'd1, 8'd2, 8'd3, 8'd3, 8'd0};
    gp[0] = 64'd10; gp[1] = 64'd20; gp[2] = 64'd30; gp[3] = 64'd40;
    k = 0;
    exp_a_q.push_back({1'b0, 72'd100});
    for (int i = 0; i < 7; i++) begin
      a_valid = vpat[i];
      a_prod  = vpat[i] ? gp[k] : 64'hBAD;
      if (vpat[i]) k++;
      tick();
      chk("gapped count", {120'd0, a_count}, {120'd0, cnt_exp[i]});
    end
    a_idle(2);

    // Asynchronous reset while holding
    a_sum_ready = 1'b0;
    a_acc(64'd300);
    a_acc(64'd300);
    a_acc(64'd300);
    a_acc(64'd400);
    a_valid = 1'b0;
    chk("pre-reset held sum", {56'd0, a_sum}, 128'd1300);
    #2;
    a_rst = 1'b1;
    #1;
    chk("async rst sum_valid", {127'd0, a_sum_valid}, 128'd0);
    chk("async rst sum", {56'd0, a_sum}, 128'd0);
    chk("async rst count", {120'd0, a_count}, 128'd0);
    chk("async rst in_ready", {127'd0, a_ready}, 128'd1);
    a_rst = 1'b0;
    a_sum_ready = 1'b1;
    tick();
    a_acc(64'd1);
    a_acc(64'd2);
    a_acc(64'd3);
    exp_a_q.push_back({1'b0, 72'd10});
    a_acc(64'd4);
    a_idle(2);

    // Overflow with COUNT=2, ACC_W=64
    b_sum_ready = 1'b1;
    b_acc(64'hFFFF_FFFF_FFFF_FFFF);
    exp_b_q.push_back({1'b1, 64'd1});
    b_acc(64'd2);
    b_valid = 1'b0;
    tick();
    b_acc(64'd5);
    exp_b_q.push_back({1'b0, 64'd11});
    b_acc(64'd6);
    b_valid = 1'b0;
    tick();
    tick();

    chk("A scoreboard drained", 128'(exp_a_q.size()), 128'd0);
    chk("B scoreboard drained", 128'(exp_b_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
